// File: rtl/history_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : history_pkg
//  Description : Shared constants and state encoding for the 2-line history
//                sequencer. The CLEAR state only exists when the optional
//                clear feature is built in (macro HISTORY_CLEAR_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package history_pkg;

    localparam int         LINE_LEN  = 16;
    localparam int         RAM_DEPTH = 2 * LINE_LEN;
    localparam logic [7:0] FILL_CHAR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_WR_IN  = 3'd2,
        ST_WR_OUT = 3'd3,
        ST_DONE   = 3'd4
`ifdef HISTORY_CLEAR_EN
        ,
        ST_CLEAR  = 3'd5
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/history_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : history_rd_arb
//  Description : Read-port arbiter for the history RAM. The sequencer owns
//                the async read port while scrolling; otherwise the LCD
//                refresher does. Read data is forwarded to the LCD as-is and
//                flagged invalid through o_lcd_stall while the port is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module history_rd_arb #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          i_seq_active,
    input  logic [AW-1:0] i_seq_raddr,
    input  logic [AW-1:0] i_lcd_raddr,
    input  logic [DW-1:0] i_ram_dout,
    output logic [AW-1:0] o_ram_raddr,
    output logic [DW-1:0] o_lcd_rdata,
    output logic          o_lcd_stall
);

    // Address mux with sequencer priority; data is a pure pass-through.
    always_comb begin
        o_ram_raddr = i_seq_active ? i_seq_raddr : i_lcd_raddr;
        o_lcd_stall = i_seq_active;
        o_lcd_rdata = i_ram_dout;
    end

endmodule
`default_nettype wire

// File: rtl/history_seq.sv
`default_nettype none
// ============================================================================
//  Module      : history_seq
//  Description : Write sequencer for the 2x16 history RAM. Each accepted
//                (plaintext, ciphertext) pair is written at the cursor of
//                line 1 / line 2; once the lines are full both are scrolled
//                left one column before the pair is appended at the end.
//                Optional clear port/state enabled by macro HISTORY_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module history_seq #(
    parameter int         LINE_LEN  = history_pkg::LINE_LEN,
    parameter int         AW        = 5,
    parameter int         DW        = 8,
    parameter logic [7:0] FILL_CHAR = history_pkg::FILL_CHAR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pair_valid,
    output logic          pair_ready,
    input  logic [DW-1:0] in_char,
    input  logic [DW-1:0] out_char,
    input  logic [AW-1:0] lcd_raddr,
    output logic [DW-1:0] lcd_rdata,
    output logic          lcd_stall,
    output logic          hist_upd,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we
`ifdef HISTORY_CLEAR_EN
    ,
    input  logic          clear
`endif
);

    import history_pkg::*;

    // Cursor must be able to hold LINE_LEN itself (the "line full" value).
    localparam int CW         = $clog2(LINE_LEN + 1);
    localparam int LAST_SHIFT = 2 * LINE_LEN - 3;
`ifdef HISTORY_CLEAR_EN
    localparam int LAST_CLEAR = 2 * LINE_LEN - 1;
`endif

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [CW-1:0] r_cursor, w_cursor_nxt;
    logic [DW-1:0] r_in_char, r_out_char;
    logic          w_latch;
    logic          w_seq_active;
    logic          w_in_line2;
    logic [AW-1:0] w_col;
    logic [AW-1:0] w_shift_waddr;
    logic [AW-1:0] w_shift_raddr;

    // Scroll addressing: idx walks the 15 moves of line 1 then line 2.
    always_comb begin
        w_in_line2    = (r_idx >= AW'(LINE_LEN - 1));
        w_col         = w_in_line2 ? (r_idx - AW'(LINE_LEN - 1)) : r_idx;
        w_shift_waddr = (w_in_line2 ? AW'(LINE_LEN) : AW'(0)) + w_col;
        w_shift_raddr = w_shift_waddr + AW'(1);
    end

    // State, index, cursor and pair-latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cursor   <= '0;
            r_in_char  <= '0;
            r_out_char <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cursor <= w_cursor_nxt;
            if (w_latch) begin
                r_in_char  <= in_char;
                r_out_char <= out_char;
            end
        end
    end

    // Next-state and RAM write-port control.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cursor_nxt = r_cursor;
        w_latch      = 1'b0;
        w_seq_active = 1'b0;
        pair_ready   = 1'b0;
        hist_upd     = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = '0;
        // Idle data bus parks on the fill character.
        ram_din      = DW'(FILL_CHAR);

        case (r_state)
            ST_IDLE: begin
`ifdef HISTORY_CLEAR_EN
                // Clear wins over a pair offered in the same cycle.
                pair_ready = !clear;
                if (clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end else
`else
                pair_ready = 1'b1;
`endif
                if (pair_valid) begin
                    w_latch = 1'b1;
                    if (r_cursor < CW'(LINE_LEN)) begin
                        w_state_nxt = ST_WR_IN;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                        w_idx_nxt   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                w_seq_active = 1'b1;
                ram_we       = 1'b1;
                ram_waddr    = w_shift_waddr;
                ram_din      = ram_dout;
                if (r_idx == AW'(LAST_SHIFT)) begin
                    w_state_nxt  = ST_WR_IN;
                    w_cursor_nxt = CW'(LINE_LEN - 1);
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            ST_WR_IN: begin
                ram_we      = 1'b1;
                ram_waddr   = AW'(r_cursor);
                ram_din     = r_in_char;
                w_state_nxt = ST_WR_OUT;
            end
            ST_WR_OUT: begin
                ram_we       = 1'b1;
                ram_waddr    = AW'(LINE_LEN) + AW'(r_cursor);
                ram_din      = r_out_char;
                w_cursor_nxt = (r_cursor >= CW'(LINE_LEN)) ? CW'(LINE_LEN)
                                                            : r_cursor + CW'(1);
                w_state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                hist_upd    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`ifdef HISTORY_CLEAR_EN
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = r_idx;
                ram_din   = DW'(FILL_CHAR);
                if (r_idx == AW'(LAST_CLEAR)) begin
                    w_cursor_nxt = '0;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    history_rd_arb #(
        .AW (AW),
        .DW (DW)
    ) u_rd_arb (
        .i_seq_active (w_seq_active),
        .i_seq_raddr  (w_shift_raddr),
        .i_lcd_raddr  (lcd_raddr),
        .i_ram_dout   (ram_dout),
        .o_ram_raddr  (ram_raddr),
        .o_lcd_rdata  (lcd_rdata),
        .o_lcd_stall  (lcd_stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_history_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_history_seq
//  Description : Scoreboard bench for history_seq with a behavioural 32x8
//                async-read RAM. Stimulus pushes expected completions; a
//                negedge monitor pops them on every hist_upd pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_history_seq;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pair_valid = 1'b0;
    logic          pair_ready;
    logic [DW-1:0] in_char = '0;
    logic [DW-1:0] out_char = '0;
    logic [AW-1:0] lcd_raddr = 5'd5;
    logic [DW-1:0] lcd_rdata;
    logic          lcd_stall;
    logic          hist_upd;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
`ifdef HISTORY_CLEAR_EN
    logic          clear = 1'b0;
`endif

    history_seq dut (
        .clk        (clk),
        .rst        (rst),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .in_char    (in_char),
        .out_char   (out_char),
        .lcd_raddr  (lcd_raddr),
        .lcd_rdata  (lcd_rdata),
        .lcd_stall  (lcd_stall),
        .hist_upd   (hist_upd),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout),
        .ram_waddr  (ram_waddr),
        .ram_din    (ram_din),
        .ram_we     (ram_we)
`ifdef HISTORY_CLEAR_EN
        ,
        .clear      (clear)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: power-up fill with spaces, sync write, async read.
    logic [7:0] mem [32];
    logic       mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_raddr];

    typedef struct {
        int           due;
        int           lat;
        int           writes;
        int           stalls;
        logic [127:0] l1;
        logic [127:0] l2;
        logic [127:0] mask;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [127:0] rd_line(input int base);
        logic [127:0] r;
        for (int c = 0; c < 16; c++) r[127-8*c -: 8] = mem[base+c];
        return r;
    endfunction

    // Line model: col 0 sits in the most significant byte.
    logic [127:0] m_l1, m_l2, m_mask;
    int           m_cur;

    // Monitor: per-transaction counters, checked at every hist_upd pulse.
    int rl = 0;
    int wc = 0;
    int sc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rl = 0; wc = 0; sc = 0;
        end else begin
            if (pair_ready) rl = 0; else rl++;
            if (ram_we) wc++;
            if (lcd_stall) sc++;
            if (!lcd_stall) chk("lcd_rdata", 128'(lcd_rdata), 128'(mem[5]));
            if (hist_upd) begin
                if (sb.size() == 0) begin
                    chk("unexpected_hist_upd", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("hist_upd_cycle", 128'(cyc), 128'(e.due));
                    chk("ready_low_cycles", 128'(rl), 128'(e.lat));
                    chk("write_count", 128'(wc), 128'(e.writes));
                    chk("stall_count", 128'(sc), 128'(e.stalls));
                    chk("line1", rd_line(0) & ~e.mask, e.l1 & ~e.mask);
                    chk("line2", rd_line(16), e.l2);
                end
                wc = 0; sc = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!pair_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit track);
        exp_t e;
        int lat;
        wait_ready();
        if (!pair_ready) begin
            fail_now("pair_ready_wait");
            return;
        end
        pair_valid = 1'b1;
        in_char    = a;
        out_char   = b;
        lat = (m_cur < 16) ? 3 : 33;
        if (m_cur < 16) begin
            m_l1[127-8*m_cur -: 8] = a;
            m_l2[127-8*m_cur -: 8] = b;
            m_cur++;
        end else begin
            m_l1   = {m_l1[119:0], a};
            m_l2   = {m_l2[119:0], b};
            m_mask = m_mask << 8;
        end
        if (track) begin
            e.due = cyc + lat; e.lat = lat;
            e.writes = (lat == 3) ? 2 : 32;
            e.stalls = (lat == 3) ? 0 : 30;
            e.l1 = m_l1; e.l2 = m_l2; e.mask = m_mask;
            sb.push_back(e);
        end
        @(negedge clk);
        pair_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pair_ready"}, 128'(pair_ready), 128'(1));
        chk({tag, "_ram_we"},     128'(ram_we),     128'(0));
        chk({tag, "_hist_upd"},   128'(hist_upd),   128'(0));
        chk({tag, "_lcd_stall"},  128'(lcd_stall),  128'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cur = 0;
        check_reset_outputs("rst_pulse");
    endtask

    initial begin
        logic [127:0] k1, k2;
        m_l1   = {16{8'h20}};
        m_l2   = {16{8'h20}};
        m_mask = '0;
        m_cur  = 0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst      = 1'b0;
        check_reset_outputs("reset");

        // First pair after reset lands in column 0 of both lines.
        send("A", "Q", 1'b1);
        wait_idle();
        k1 = "A               ";
        k2 = "Q               ";
        chk("first_line1", rd_line(0), k1);
        chk("first_line2", rd_line(16), k2);

        // Fill both lines from column 0.
        pulse_reset();
        for (int i = 0; i < 16; i++) send(8'("A" + i), 8'("a" + i), 1'b1);
        wait_idle();
        k1 = "ABCDEFGHIJKLMNOP";
        k2 = "abcdefghijklmnop";
        chk("full_line1", rd_line(0), k1);
        chk("full_line2", rd_line(16), k2);

        // 17th pair scrolls both lines.
        send("Z", "z", 1'b1);
        wait_idle();
        k1 = "BCDEFGHIJKLMNOPZ";
        k2 = "bcdefghijklmnopz";
        chk("scroll_line1", rd_line(0), k1);
        chk("scroll_line2", rd_line(16), k2);

        // Abort a scroll with reset at idx 10 (accept cycle + 11).
        send("Y", "y", 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_write", 128'(ram_we), 128'(0));
        end
        // Line 1 cols 0..9 moved; col 10 is at the abort boundary; line 2 untouched.
        m_l1   = "CDEFGHIJKLMMNOPZ";
        m_l2   = "bcdefghijklmnopz";
        m_mask = 128'hFF << (8 * (15 - 10));
        m_cur  = 0;
        send("X", "x", 1'b1);
        send("W", "w", 1'b1);
        wait_idle();
        k2 = "xwdefghijklmnopz";
        chk("post_abort_line2", rd_line(16), k2);

`ifdef HISTORY_CLEAR_EN
        begin
            exp_t e;
            @(negedge clk);
            clear      = 1'b1;
            pair_valid = 1'b1;
            in_char    = "K";
            out_char   = "k";
            chk("clear_blocks_ready", 128'(pair_ready), 128'(0));
            e.due = cyc + 33; e.lat = 33; e.writes = 32; e.stalls = 0;
            e.l1 = {16{8'h20}}; e.l2 = {16{8'h20}}; e.mask = '0;
            sb.push_back(e);
            @(negedge clk);
            clear      = 1'b0;
            pair_valid = 1'b0;
            wait_idle();
            m_l1 = {16{8'h20}}; m_l2 = {16{8'h20}}; m_mask = '0; m_cur = 0;
            send("M", "m", 1'b1);
            wait_idle();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
